pcm_sample_buffer: RTL and testbench
====================================

# pcm_sample_buffer

Receive-side companion to the PCM clock divider. It treats every transition of the divider's `we_pcm` toggle as one sample strobe and captures `pcm_in` into a small FIFO on each strobe. It then delivers the samples downstream over a valid/ready handshake, with occupancy reporting and sticky overflow detection. It sits between the PCM sample source (paced by the divider) and the sonar processing chain.

## Interface
- `W`, 16: PCM sample width in bits.
- `AW`, 3: log2 of FIFO depth (depth = 2^AW = 8).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `we_pcm`  in  1  toggle strobe from clock divider; each 0->1 or 1->0 transition = one sample period.
- `pcm_in`  in  W  sample data; must be stable at the first `clk` edge after a `we_pcm` transition.
- `out_data`  out  W  head-of-FIFO sample (show-ahead); valid only while `out_valid`=1.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `level`  out  AW+1  current occupancy, 0..2^AW.
- `overflow`  out  1  sticky: a strobe arrived while full and the sample was dropped.
- `clr_ovf`  in  1  synchronous clear of `overflow`.

## Operation
- **Edge detect**
  - `we_pcm_d` registers `we_pcm` every cycle.
  - `armed` is 0 after reset and sets to 1 at the first clock edge.
  - strobe = armed & (we_pcm ^ we_pcm_d).
  - The first cycle after reset release never produces a strobe, whatever the level of `we_pcm`.
- **Push:** on a strobe, write `pcm_in` to `mem[wr_ptr]` and increment `wr_ptr`, unless the FIFO is full and no pop occurs that cycle.
- **Pop:** when `out_valid` & `out_ready`, increment `rd_ptr`.
- **Pointers:** AW+1 bits with natural wrap.
  - Address = low AW bits.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and low bits equal.
  - `level` = wr_ptr − rd_ptr (modulo 2^(AW+1)).
- **`out_data`:** `mem[rd_ptr[AW-1:0]]`, read combinationally. `out_valid` = !empty.
- **Simultaneous push and pop**
  - Both always take effect when not full.
  - When full, the pop frees a slot, so the push is accepted, `level` stays at 2^AW, and there is no overflow.
  - When empty, only the push occurs; there is no pop because `out_valid`=0.
- **Overflow:** set on a strobe while full with no simultaneous pop. Cleared by `clr_ovf`. Set wins if both happen in the same cycle. Dropped samples do not disturb pointers or `mem`.
- **Reset (asynchronous, any time)**
  - Clears `wr_ptr`, `rd_ptr`, `we_pcm_d`, `armed` and `overflow`. Zeroes `mem`.
  - FIFO contents are discarded mid-operation.
  - Outputs under reset: `out_valid`=0, `level`=0, `overflow`=0, `out_data`=0.

## Timing
- `we_pcm` changes after edge k. The strobe is detected and `pcm_in` is written at edge k+1.
- `out_valid` rises after edge k+1, giving a 1-cycle capture latency into an empty FIFO.
- Pop is accepted at the edge where `out_valid` & `out_ready`. The next sample is presented combinationally after that edge.
- Sustained throughput: one sample per cycle in and out. Minimum strobe spacing is 1 cycle (divider C=1 toggles every cycle).
- `level` and `overflow` are registered and update at the same edge as the corresponding push, pop or clear.
- No combinational path from `out_ready` to `out_valid`.

## Test plan
- **Basic capture:** reset, toggle `we_pcm` 4 times with `pcm_in`=0x0011, 0x0022, 0x0033, 0x0044 and `out_ready`=0 -> `level`=4, `out_data`=0x0011. Then hold `out_ready`=1 -> outputs 0x0011..0x0044 in order over 4 cycles, then `out_valid`=0 and `level`=0.
- **Overflow:** with `out_ready`=0, 10 strobes with values 1..10 -> `level`=8, `overflow`=1, drained sequence 1..8. `clr_ovf` pulse -> `overflow`=0. A `clr_ovf` coincident with a dropped strobe -> `overflow` stays 1.
- **Full plus simultaneous pop:** fill to 8, then strobe with value 0xAAAA while `out_ready`=1 -> `overflow`=0, `level`=8, 0xAAAA is the last sample drained.
- **Pointer wrap:** stream 40 samples with `out_ready`=1 and the divider at C=3 -> all 40 are received in order, `level` is never >1, no overflow.
- **Reset behaviour:** assert `rst`=0 mid-stream with `level`=5 -> `out_valid`, `level`, `overflow` go to 0 immediately. Release with `we_pcm`=1 -> no spurious capture (`level` remains 0) until the next `we_pcm` transition.

Source files
------------

// File: rtl/pcm_sample_buffer.sv
// PCM receive-side sample buffer: captures pcm_in on every we_pcm transition into
// a small show-ahead FIFO and hands samples downstream over valid/ready.
module pcm_sample_buffer #(
    parameter int W  = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_pcm,
    input  logic [W-1:0]  pcm_in,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          clr_ovf
);

    localparam int DEPTH = 1 << AW;

    logic          we_pcm_q;
    logic          armed_q;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [W-1:0]  mem_q [DEPTH];

    logic          strobe_s;
    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;

    // Strobe detection and FIFO status from registered pointers only
    always_comb begin
        strobe_s = armed_q & (we_pcm ^ we_pcm_q);
        empty_s  = (wr_ptr_q == rd_ptr_q);
        full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_s    = ~empty_s & out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
        push_s   = strobe_s & (~full_s | pop_s);
        drop_s   = strobe_s & full_s & ~pop_s;
    end

    // Next-state for pointers, occupancy and sticky overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        level_d = wr_ptr_d - rd_ptr_d;
        // Set has priority over clear
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_pcm_q <= 1'b0;
            armed_q  <= 1'b0;
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
            level_q  <= {(AW+1){1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            we_pcm_q <= we_pcm;
            armed_q  <= 1'b1;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Sample storage, zeroed on reset so out_data reads 0 while empty after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= pcm_in;
        end
    end

    // Output mapping
    always_comb begin
        out_data  = mem_q[rd_ptr_q[AW-1:0]];
        out_valid = ~empty_s;
        level     = level_q;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_pcm_sample_buffer.sv
// Scoreboard bench for pcm_sample_buffer: expected samples queued when strobes are
// driven, compared as the DUT hands them out.
module tb_pcm_sample_buffer;

    localparam int W  = 16;
    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic          we_pcm;
    logic [W-1:0]  pcm_in;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   level;
    logic          overflow;
    logic          clr_ovf;

    int            n_chk;
    int            n_err;
    int            mcount;
    bit            m_ovf;
    logic [W-1:0]  sb [$];

    pcm_sample_buffer #(.W(W), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .we_pcm    (we_pcm),
        .pcm_in    (pcm_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Pops are accepted at the next rising edge; compare the presented head here
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            check_eq("pop_avail", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                check_eq("pop_data", 32'(out_data), 32'(sb.pop_front()));
            end
        end
    end

    // One clock cycle: drive inputs, advance the model, then check registered state
    task automatic step(input bit tog, input logic [W-1:0] d, input bit rdy, input bit clr);
        bit pop, full, drop;
        if (tog) we_pcm = ~we_pcm;
        pcm_in    = d;
        out_ready = rdy;
        clr_ovf   = clr;
        pop  = (mcount != 0) && rdy;
        full = (mcount == 8);
        drop = tog && full && !pop;
        if (tog && !drop) begin
            sb.push_back(d);
            mcount++;
        end
        if (pop) mcount--;
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        check_eq("level", 32'(level), 32'(mcount));
        check_eq("out_valid", 32'(out_valid), 32'(mcount != 0));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        if (mcount != 0 && sb.size() != 0) begin
            check_eq("head", 32'(out_data), 32'(sb[0]));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && mcount != 0; i++) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0);
        end
        check_eq("drain_sb_empty", 32'(sb.size()), 32'd0);
        check_eq("drain_level", 32'(level), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_err = 0; mcount = 0; m_ovf = 1'b0;
        rst = 1'b0; we_pcm = 1'b0; pcm_in = 16'h0000; out_ready = 1'b0; clr_ovf = 1'b0;
        #12;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic capture then drain
        step(1'b1, 16'h0011, 1'b0, 1'b0);
        step(1'b1, 16'h0022, 1'b0, 1'b0);
        step(1'b1, 16'h0033, 1'b0, 1'b0);
        step(1'b1, 16'h0044, 1'b0, 1'b0);
        check_eq("basic_level4", 32'(level), 32'd4);
        check_eq("basic_head", 32'(out_data), 32'h0011);
        drain();

        // Overflow: 10 strobes into 8 slots, clear, then clear colliding with a drop
        for (int i = 1; i <= 10; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        check_eq("ovf_cleared", 32'(overflow), 32'd0);
        step(1'b1, 16'h00EE, 1'b0, 1'b1);
        check_eq("ovf_set_wins", 32'(overflow), 32'd1);
        drain();
        step(1'b0, 16'h0000, 1'b0, 1'b1);

        // Full plus simultaneous pop
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
        step(1'b1, 16'hAAAA, 1'b1, 1'b0);
        check_eq("fullpop_level", 32'(level), 32'd8);
        check_eq("fullpop_ovf", 32'(overflow), 32'd0);
        drain();

        // Pointer wrap with divider toggling every 3 cycles
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 16'h1000 + 16'(i), 1'b1, 1'b0);
            check_eq("wrap_lvl_le1", 32'(level <= 1), 32'd1);
            step(1'b0, 16'h0000, 1'b1, 1'b0);
            step(1'b0, 16'h0000, 1'b1, 1'b0);
        end
        check_eq("wrap_all_rx", 32'(sb.size()), 32'd0);
        check_eq("wrap_ovf", 32'(overflow), 32'd0);

        // Asynchronous reset mid-stream with 5 queued
        for (int i = 0; i < 5; i++) step(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0);
        check_eq("pre_rst_level", 32'(level), 32'd5);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_level", 32'(level), 32'd0);
        check_eq("arst_ovf", 32'(overflow), 32'd0);
        check_eq("arst_data", 32'(out_data), 32'd0);
        sb.delete();
        mcount = 0;
        m_ovf  = 1'b0;
        we_pcm = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 16'h7777, 1'b0, 1'b0);
        check_eq("no_spurious", 32'(level), 32'd0);
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        check_eq("post_rst_cap", 32'(level), 32'd1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
